// File: rtl/aibcr3_dll_intp_seq.sv
// Step sequencer for the DLL 8-phase interpolator gray control: walks a 3-bit
// gray code one step at a time toward an accepted target, with a settle wait after each step.
//
// state  | meaning
// IDLE   | waiting for a target handshake (tgt_rdy = ~hold)
// STEP   | move cur_code/gray one code toward tgt_q, load settle counter
// SETTLE | count settle cycles; exit on zero unless hold is high
// DONE   | one-cycle done pulse, then back to IDLE
module aibcr3_dll_intp_seq #(
   parameter int SETTLE_CYC = 4,
   parameter int INIT_CODE  = 0
) (
   input  logic       CLKIN,
   input  logic       RSTb,
   input  logic [2:0] tgt_code,
   input  logic       tgt_vld,
   output logic       tgt_rdy,
   input  logic       hold,
   output logic [2:0] gray,
   output logic [2:0] cur_code,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STEP   = 2'd1,
      ST_SETTLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [2:0] INIT_BIN    = 3'(INIT_CODE);
   localparam logic [2:0] INIT_GRAY   = INIT_BIN ^ {1'b0, INIT_BIN[2:1]};
   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);

   state_t     state_q, state_d;
   logic [2:0] cur_q, cur_d;
   logic [2:0] gray_q, gray_d;
   logic [2:0] tgt_q, tgt_d;
   logic [7:0] cnt_q, cnt_d;

   always_ff @(posedge CLKIN or negedge RSTb) begin
      if (!RSTb) begin
         state_q <= ST_IDLE;
         cur_q   <= INIT_BIN;
         gray_q  <= INIT_GRAY;
         tgt_q   <= INIT_BIN;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         gray_q  <= gray_d;
         tgt_q   <= tgt_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      tgt_d   = tgt_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (tgt_vld && !hold) begin
               tgt_d   = tgt_code;
               state_d = (tgt_code == cur_q) ? ST_DONE : ST_STEP;
            end
         end
         ST_STEP: begin
            // End-stop guards keep the binary code from wrapping 7<->0.
            if ((tgt_q > cur_q) && (cur_q != 3'd7)) begin
               cur_d = cur_q + 3'd1;
            end else if ((tgt_q < cur_q) && (cur_q != 3'd0)) begin
               cur_d = cur_q - 3'd1;
            end
            cnt_d   = SETTLE_LOAD;
            state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else if (!hold) begin
               state_d = (cur_q == tgt_q) ? ST_DONE : ST_STEP;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      gray_d = cur_d ^ {1'b0, cur_d[2:1]};
   end

   assign tgt_rdy  = (state_q == ST_IDLE) && !hold;
   assign gray     = gray_q;
   assign cur_code = cur_q;
   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_aibcr3_dll_intp_seq.sv
// Bench for aibcr3_dll_intp_seq: event-schedule reference model checked every cycle,
// directed scenarios with literal latency/sequence expectations, then random traffic.
module tb_aibcr3_dll_intp_seq;
   localparam int S = 4;

   logic       CLKIN = 1'b0;
   logic       RSTb = 1'b0;
   logic [2:0] tgt_code = 3'd0;
   logic       tgt_vld = 1'b0;
   logic       hold = 1'b0;
   logic       tgt_rdy, busy, done;
   logic [2:0] gray, cur_code;

   aibcr3_dll_intp_seq #(.SETTLE_CYC(S), .INIT_CODE(0)) dut (
      .CLKIN(CLKIN), .RSTb(RSTb), .tgt_code(tgt_code), .tgt_vld(tgt_vld),
      .tgt_rdy(tgt_rdy), .hold(hold), .gray(gray), .cur_code(cur_code),
      .busy(busy), .done(done));

   always #5 CLKIN = ~CLKIN;

   int n_chk = 0;
   int n_pass = 0;
   int edge_n = 0;

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
   endtask

   always @(posedge CLKIN) edge_n++;

   // Reference: gray order table and a schedule of edge numbers at which things happen.
   int gray_tbl[8] = '{0, 1, 3, 2, 6, 7, 5, 4};
   int m_cur, m_tgt, m_step_at, m_dec_at, m_done_at;
   int cyc = 0;
   bit m_idle;

   always @(posedge CLKIN or negedge RSTb) begin
      if (!RSTb) begin
         m_cur = 0; m_tgt = 0; m_idle = 1'b1;
         m_step_at = -1; m_dec_at = -1; m_done_at = -1;
      end else begin
         cyc++;
         if (m_idle) begin
            if (tgt_vld && !hold) begin
               m_tgt  = int'(tgt_code);
               m_idle = 1'b0;
               if (m_tgt == m_cur) m_done_at = cyc;
               else m_step_at = cyc + 1;
            end
         end else if (cyc == m_step_at) begin
            m_cur    = m_cur + ((m_tgt > m_cur) ? 1 : -1);
            m_dec_at = cyc + S;
         end else if (cyc == m_dec_at) begin
            if (hold) m_dec_at = m_dec_at + 1;
            else if (m_cur == m_tgt) m_done_at = cyc;
            else m_step_at = cyc + 1;
         end else if (cyc == m_done_at + 1) begin
            m_idle = 1'b1;
         end
      end
   end

   logic [2:0] prev_gray = 3'd0;
   bit         prev_ok = 1'b0;

   always @(negedge CLKIN) begin
      check("gray", int'(gray), gray_tbl[m_cur]);
      check("cur_code", int'(cur_code), m_cur);
      check("busy", int'(busy), int'(!m_idle));
      check("done", int'(done), int'(!m_idle && (m_done_at == cyc)));
      check("tgt_rdy", int'(tgt_rdy), int'(m_idle && !hold));
      if (prev_ok && RSTb && (gray != prev_gray))
         check("gray_onebit", $countones(gray ^ prev_gray), 1);
      prev_gray = gray;
      prev_ok   = RSTb;
   end

   int e0 = 0;
   int seq_g[$];
   int seq_t[$];

   task automatic tick();
      @(posedge CLKIN);
      #2;
   endtask

   task automatic send(input int code);
      int k;
      k = 0;
      while (!tgt_rdy && k < 500) begin
         tick();
         k++;
      end
      if (!tgt_rdy) check("rdy_timeout", 0, 1);
      tgt_vld  = 1'b1;
      tgt_code = 3'(code);
      tick();
      e0      = edge_n;
      tgt_vld = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      logic [2:0] pg;
      lat = -1;
      pg  = gray;
      seq_g.delete();
      seq_t.delete();
      for (int k = 0; k < 500; k++) begin
         if (gray != pg) begin
            seq_g.push_back(int'(gray));
            seq_t.push_back(edge_n - e0);
            pg = gray;
         end
         if (done) begin
            lat = edge_n - e0;
            break;
         end
         tick();
      end
   endtask

   task automatic check_seq(input string nm, input int exp_g[$]);
      check({nm, "_len"}, seq_g.size(), exp_g.size());
      for (int i = 0; i < exp_g.size() && i < seq_g.size(); i++) begin
         check({nm, "_gray"}, seq_g[i], exp_g[i]);
         check({nm, "_time"}, seq_t[i], 1 + i * (S + 1));
      end
   endtask

   initial begin
      int lat;
      int exp_up[$]   = '{1, 3, 2, 6, 7, 5, 4};
      int exp_down[$] = '{5, 7, 6, 2, 3};

      tick(); tick();
      check("rst_gray", int'(gray), 0);
      check("rst_cur", int'(cur_code), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_rdy", int'(tgt_rdy), 1);
      RSTb = 1'b1;
      tick();
      check("post_rst_gray", int'(gray), 0);
      check("post_rst_rdy", int'(tgt_rdy), 1);

      send(7); wait_done(lat);
      check("lat_0to7", lat, 35);
      check_seq("seq_0to7", exp_up);
      check("gray_at7", int'(gray), 3'b100);

      send(2); wait_done(lat);
      check("lat_7to2", lat, 25);
      check_seq("seq_7to2", exp_down);

      send(5); wait_done(lat);
      check("lat_2to5", lat, 15);

      send(5);
      check("eq_busy_first", int'(busy), 1);
      wait_done(lat);
      check("lat_eq", lat, 0);
      tick();
      check("eq_busy_after", int'(busy), 0);
      check("eq_gray", int'(gray), 3'b111);

      send(0); wait_done(lat);
      check("lat_5to0", lat, 25);

      hold = 1'b1; tgt_vld = 1'b1; tgt_code = 3'd6;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_idle_rdy", int'(tgt_rdy), 0);
         check("hold_idle_busy", int'(busy), 0);
      end
      tgt_vld = 1'b0; hold = 1'b0;
      tick();

      send(3);
      for (int i = 0; i < 4; i++) tick();
      hold = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      hold = 1'b0;
      wait_done(lat);
      check("lat_hold", lat, 18);
      check("hold_step2_time", (seq_t.size() > 0) ? seq_t[0] : -1, 9);

      send(7);
      for (int k = 0; k < 100 && cur_code != 3'd4; k++) tick();
      check("mid_walk_at4", int'(cur_code), 4);
      #1 RSTb = 1'b0;
      #1;
      check("async_rst_gray", int'(gray), 0);
      check("async_rst_cur", int'(cur_code), 0);
      check("async_rst_busy", int'(busy), 0);
      check("async_rst_done", int'(done), 0);
      tick(); tick();
      RSTb = 1'b1;
      tick();
      send(6); wait_done(lat);
      check("lat_after_rst", lat, 30);
      check("gray_at6", int'(gray), 3'b101);

      for (int i = 0; i < 2000; i++) begin
         hold     = ($urandom_range(0, 7) == 0);
         tgt_vld  = ($urandom_range(0, 2) == 0);
         tgt_code = 3'($urandom_range(0, 7));
         tick();
      end
      hold = 1'b0; tgt_vld = 1'b0;
      for (int i = 0; i < 60; i++) tick();
      check("drain_idle", int'(busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
